ysyx_24110015_wb_scoreboard: RTL and testbench

Writeback-side driver for the integer register file. Buffers execute results in a small FIFO, drives the register file's single write port, and tracks outstanding destination registers in a per-register pending counter. Decode reads the counters to detect RAW hazards. Sits between EXU and the register file write port, facing the same address/data widths as the register file.

---
 rtl/ysyx_24110015_wb_scoreboard_if.sv | 49 ++++
 rtl/ysyx_24110015_wb_scoreboard.sv | 117 +++++++++++
 tb/tb_ysyx_24110015_wb_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_wb_scoreboard_if.sv
// Bundle between EXU/IDU, the writeback scoreboard and the register file write port.
// The scoreboard sits on the slave modport; the surrounding pipeline drives the master side.
interface ysyx_24110015_wb_scoreboard_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   // Result input from EXU
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_wen;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic [DATA_WIDTH-1:0] in_data;

   // Issue from IDU
   logic                  iss_valid;
   logic                  iss_wen;
   logic [ADDR_WIDTH-1:0] iss_rd;
   logic                  iss_ready;

   // Hazard query
   logic [ADDR_WIDTH-1:0] q_rs1;
   logic [ADDR_WIDTH-1:0] q_rs2;
   logic                  q_busy1;
   logic                  q_busy2;

   // Register file write port
   logic                  rf_hold;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   modport master (
      output in_valid, in_wen, in_rd, in_data,
      output iss_valid, iss_wen, iss_rd,
      output q_rs1, q_rs2,
      output rf_hold,
      input  in_ready, iss_ready, q_busy1, q_busy2,
      input  rf_wen, rf_waddr, rf_wdata
   );

   modport slave (
      input  in_valid, in_wen, in_rd, in_data,
      input  iss_valid, iss_wen, iss_rd,
      input  q_rs1, q_rs2,
      input  rf_hold,
      output in_ready, iss_ready, q_busy1, q_busy2,
      output rf_wen, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/ysyx_24110015_wb_scoreboard.sv
// Writeback scoreboard: result FIFO in front of the register file write port, plus
// a 2-bit pending-write counter per architectural register for RAW hazard detection.
module ysyx_24110015_wb_scoreboard #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input logic                          clk,
   input logic                          rst,
   ysyx_24110015_wb_scoreboard_if.slave sb
);
   localparam int NREG  = 2 ** ADDR_WIDTH;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic                  wen;
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t           fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       pend_q [NREG];
   logic [1:0]       pend_d [NREG];

   entry_t           head;
   logic             empty;
   logic             push;
   logic             pop;
   logic             head_wr;
   logic             iss_fire;
   logic             underflow;
   logic [NREG-1:0]  inc_vec;
   logic [NREG-1:0]  dec_vec;

   assign head  = fifo_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign push  = sb.in_valid && sb.in_ready;
   // Entries with wen = 0 or rd = 0 still pop; they simply never strobe the register file.
   assign pop     = !empty && !sb.rf_hold;
   assign head_wr = pop && head.wen && (head.rd != '0);

   assign sb.in_ready = !rst && (count_q != CNT_W'(DEPTH));
   assign sb.rf_wen   = !rst && head_wr;
   assign sb.rf_waddr = head.rd;
   assign sb.rf_wdata = head.data;

   assign sb.iss_ready = !(sb.iss_wen && (sb.iss_rd != '0) && (pend_q[sb.iss_rd] == 2'd3));
   assign iss_fire     = sb.iss_valid && sb.iss_ready && sb.iss_wen && (sb.iss_rd != '0);

   assign sb.q_busy1 = (sb.q_rs1 != '0) && (pend_q[sb.q_rs1] != 2'd0);
   assign sb.q_busy2 = (sb.q_rs2 != '0) && (pend_q[sb.q_rs2] != 2'd0);

   // One-hot increment/decrement requests; bit 0 can never be set by construction.
   assign inc_vec = iss_fire ? (NREG'(1) << sb.iss_rd) : '0;
   assign dec_vec = head_wr  ? (NREG'(1) << head.rd)   : '0;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path
      // through the ifs/case can leave a signal unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      pend_d[0] = 2'd0;
      for (int i = 1; i < NREG; i++) begin
         pend_d[i] = pend_q[i];
         if (inc_vec[i] && !dec_vec[i] && (pend_q[i] != 2'd3)) begin
            pend_d[i] = pend_q[i] + 2'd1;
         end else if (dec_vec[i] && !inc_vec[i] && (pend_q[i] != 2'd0)) begin
            pend_d[i] = pend_q[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order across processes.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < NREG; i++) pend_q[i] <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   // NOTE: the FIFO payload is deliberately not reset; count_q alone says which slots
   // are valid, and leaving the storage reset-free lets it map onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{wen: sb.in_wen, rd: sb.in_rd, data: sb.in_data};
      end
   end

   // A write retiring against a zero counter means EXU produced a result nobody issued.
   assign underflow = head_wr && !inc_vec[head.rd] && (pend_q[head.rd] == 2'd0);

   a_no_pend_underflow : assert property (@(posedge clk) disable iff (rst) !underflow);

endmodule

// File: tb/tb_ysyx_24110015_wb_scoreboard.sv
// Directed bench for the writeback scoreboard: reset, flow, backpressure, counter
// saturation, simultaneous events, register 0 handling and mid-run reset.
module tb_ysyx_24110015_wb_scoreboard;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   ysyx_24110015_wb_scoreboard_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   ysyx_24110015_wb_scoreboard #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(32),
      .DEPTH     (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sb (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge; inputs are changed here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_wen    = 1'b0;
      bus.in_rd     = '0;
      bus.in_data   = '0;
      bus.iss_valid = 1'b0;
      bus.iss_wen   = 1'b0;
      bus.iss_rd    = '0;
      bus.q_rs1     = '0;
      bus.q_rs2     = '0;
      bus.rf_hold   = 1'b0;
   endtask

   task automatic push_in(input logic wen, input logic [4:0] rd, input logic [31:0] data);
      bus.in_valid = 1'b1;
      bus.in_wen   = wen;
      bus.in_rd    = rd;
      bus.in_data  = data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      push_in(1'b1, 5'd9, 32'h0000_1234);
      bus.q_rs1 = 5'd9;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", k, bus.in_ready); end
         n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen cyc%0d: got %b want 0", k, bus.rf_wen); end
         n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_q_busy1 cyc%0d: got %b want 0", k, bus.q_busy1); end
         cyc();
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL post_reset_rf_wen: got %b want 0", bus.rf_wen); end
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL post_reset_q_busy1: got %b want 0", bus.q_busy1); end
      cyc();
   endtask

   task automatic test_basic_flow();
      idle();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd5; bus.q_rs1 = 5'd5;
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL basic_iss_ready: got %b want 1", bus.iss_ready); end
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_before_issue: got %b want 0", bus.q_busy1); end
      cyc();
      bus.iss_valid = 1'b0;
      push_in(1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_after_issue: got %b want 1", bus.q_busy1); end
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL basic_rf_wen_empty: got %b want 0", bus.rf_wen); end
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b1) begin n_bad++; $display("FAIL basic_rf_wen: got %b want 1", bus.rf_wen); end
      n_cmp++; if (bus.rf_waddr !== 5'd5) begin n_bad++; $display("FAIL basic_rf_waddr: got %0d want 5", bus.rf_waddr); end
      n_cmp++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_rf_wdata: got %h want deadbeef", bus.rf_wdata); end
      n_cmp++; if (bus.q_busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_write_cycle: got %b want 1", bus.q_busy1); end
      cyc();
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL basic_rf_wen_after: got %b want 0", bus.rf_wen); end
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after_write: got %b want 0", bus.q_busy1); end
   endtask

   task automatic test_backpressure();
      idle();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd10;
      cyc();
      bus.iss_rd = 5'd11;
      cyc();
      bus.iss_valid = 1'b0;
      bus.q_rs1 = 5'd10; bus.q_rs2 = 5'd11;
      bus.rf_hold = 1'b1;
      push_in(1'b1, 5'd10, 32'h1111_0000);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_first: got %b want 1", bus.in_ready); end
      cyc();
      push_in(1'b1, 5'd11, 32'h2222_0000);
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL bp_hold_blocks_write: got %b want 0", bus.rf_wen); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_second: got %b want 1", bus.in_ready); end
      cyc();
      push_in(1'b0, 5'd12, 32'h3333_0000);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready cyc%0d: got %b want 0", k, bus.in_ready); end
         n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL bp_full_rf_wen cyc%0d: got %b want 0", k, bus.rf_wen); end
         n_cmp++; if ({bus.q_busy1, bus.q_busy2} !== 2'b11) begin n_bad++; $display("FAIL bp_busy_held cyc%0d: got %b want 11", k, {bus.q_busy1, bus.q_busy2}); end
         cyc();
      end
      bus.rf_hold = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'h1111_0000) begin
         n_bad++; $display("FAIL bp_first_write: got wen=%b addr=%0d data=%h want wen=1 addr=10 data=11110000", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
      end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_at_first_pop: got %b want 0", bus.in_ready); end
      cyc();
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'h2222_0000) begin
         n_bad++; $display("FAIL bp_second_write: got wen=%b addr=%0d data=%h want wen=1 addr=11 data=22220000", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
      end
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b0 || bus.rf_wdata !== 32'h3333_0000) begin
         n_bad++; $display("FAIL bp_third_no_write: got wen=%b data=%h want wen=0 data=33330000", bus.rf_wen, bus.rf_wdata);
      end
      n_cmp++; if ({bus.q_busy1, bus.q_busy2} !== 2'b00) begin n_bad++; $display("FAIL bp_busy_cleared: got %b want 00", {bus.q_busy1, bus.q_busy2}); end
      cyc();
   endtask

   task automatic test_saturation();
      idle();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_issue%0d_ready: got %b want 1", k, bus.iss_ready); end
         cyc();
      end
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b0) begin n_bad++; $display("FAIL sat_fourth_ready: got %b want 0", bus.iss_ready); end
      bus.iss_valid = 1'b0;
      bus.iss_rd = 5'd8;
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_other_rd_ready: got %b want 1", bus.iss_ready); end
      push_in(1'b1, 5'd7, 32'h0000_0077);
      cyc();
      bus.in_valid = 1'b0;
      bus.iss_rd = 5'd7;
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b0) begin n_bad++; $display("FAIL sat_ready_during_write: got %b want 0", bus.iss_ready); end
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd7) begin n_bad++; $display("FAIL sat_write: got wen=%b addr=%0d want wen=1 addr=7", bus.rf_wen, bus.rf_waddr); end
      cyc();
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_after_write: got %b want 1", bus.iss_ready); end
      bus.iss_wen = 1'b0;
   endtask

   task automatic test_simultaneous();
      idle();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd3; bus.q_rs1 = 5'd3;
      cyc();
      bus.iss_valid = 1'b0;
      push_in(1'b1, 5'd3, 32'h0000_000A);
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b1) begin n_bad++; $display("FAIL sim_busy_issued: got %b want 1", bus.q_busy1); end
      cyc();
      bus.in_valid = 1'b0;
      bus.iss_valid = 1'b1;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.iss_ready !== 1'b1) begin
         n_bad++; $display("FAIL sim_pop_and_issue: got wen=%b addr=%0d iss_ready=%b want 1/3/1", bus.rf_wen, bus.rf_waddr, bus.iss_ready);
      end
      cyc();
      bus.iss_valid = 1'b0;
      push_in(1'b1, 5'd3, 32'h0000_000B);
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b1) begin n_bad++; $display("FAIL sim_pend_unchanged: got %b want 1", bus.q_busy1); end
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'h0000_000B) begin n_bad++; $display("FAIL sim_second_write: got wen=%b data=%h want 1/0000000b", bus.rf_wen, bus.rf_wdata); end
      cyc();
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL sim_pend_exact: got %b want 0", bus.q_busy1); end

      push_in(1'b0, 5'd4, 32'h0000_0001);
      cyc();
      push_in(1'b0, 5'd4, 32'h0000_0002);
      #1;
      n_cmp++; if (bus.rf_wdata !== 32'h0000_0001 || bus.rf_wen !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL sim_pushpop_head: got data=%h wen=%b ready=%b want 00000001/0/1", bus.rf_wdata, bus.rf_wen, bus.in_ready);
      end
      cyc();
      bus.rf_hold = 1'b1;
      push_in(1'b0, 5'd4, 32'h0000_0003);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.rf_wdata !== 32'h0000_0002) begin
         n_bad++; $display("FAIL sim_count_stays_one: got ready=%b data=%h want 1/00000002", bus.in_ready, bus.rf_wdata);
      end
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL sim_count_two: got ready=%b want 0", bus.in_ready); end
      bus.rf_hold = 1'b0;
      cyc();
      #1;
      n_cmp++; if (bus.rf_wdata !== 32'h0000_0003 || bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL sim_drain_order: got data=%h ready=%b want 00000003/1", bus.rf_wdata, bus.in_ready);
      end
      cyc();
   endtask

   task automatic test_reg0();
      idle();
      push_in(1'b1, 5'd0, 32'h0000_0055);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL r0_no_write: got %b want 0", bus.rf_wen); end
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL r0_busy: got %b want 0", bus.q_busy1); end
      cyc();
      push_in(1'b0, 5'd6, 32'h0000_0066);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h0000_0066) begin
         n_bad++; $display("FAIL r0_entry_popped: got addr=%0d data=%h want 6/00000066", bus.rf_waddr, bus.rf_wdata);
      end
      cyc();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd0;
      #1;
      n_cmp++; if (bus.iss_ready !== 1'b1) begin n_bad++; $display("FAIL r0_iss_ready: got %b want 1", bus.iss_ready); end
      cyc();
      bus.iss_valid = 1'b0;
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b0 || bus.q_busy2 !== 1'b0) begin n_bad++; $display("FAIL r0_busy_after_issue: got %b%b want 00", bus.q_busy1, bus.q_busy2); end
   endtask

   task automatic test_reset_flush();
      idle();
      bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd20;
      cyc();
      bus.iss_rd = 5'd21;
      cyc();
      bus.iss_valid = 1'b0;
      bus.q_rs1 = 5'd20; bus.q_rs2 = 5'd21;
      bus.rf_hold = 1'b1;
      push_in(1'b1, 5'd20, 32'h0000_2020);
      cyc();
      push_in(1'b1, 5'd21, 32'h0000_2121);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      n_cmp++; if ({bus.q_busy1, bus.q_busy2} !== 2'b11) begin n_bad++; $display("FAIL flush_busy_before: got %b want 11", {bus.q_busy1, bus.q_busy2}); end
      rst = 1'b1;
      bus.rf_hold = 1'b0;
      #1;
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL flush_no_write_in_reset: got %b want 0", bus.rf_wen); end
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (bus.rf_wen !== 1'b0) begin n_bad++; $display("FAIL flush_no_write cyc%0d: got %b want 0", k, bus.rf_wen); end
         n_cmp++; if ({bus.q_busy1, bus.q_busy2} !== 2'b00) begin n_bad++; $display("FAIL flush_busy cyc%0d: got %b want 00", k, {bus.q_busy1, bus.q_busy2}); end
         cyc();
      end
      bus.q_rs1 = 5'd7;
      #1;
      n_cmp++; if (bus.q_busy1 !== 1'b0) begin n_bad++; $display("FAIL flush_old_pend7: got %b want 0", bus.q_busy1); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      idle();
      test_reset();
      test_basic_flow();
      test_backpressure();
      test_saturation();
      test_simultaneous();
      test_reg0();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
